// File: rtl/pipe_pkg.sv
// Purpose: shared types and widths for the pipeline skid-register stage.
// Contents: pipe_state_t (stage occupancy state), COUNT_W (width of the count port).
package pipe_pkg;

   localparam int unsigned COUNT_W = 2;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_BUSY  = 2'd1,
      PS_FULL  = 2'd2
   } pipe_state_t;

endpackage

// File: rtl/pipe_data_reg.sv
// Purpose: single payload register with synchronous active-high reset and load enable.
// Ports:
//   clk   in  rising-edge clock
//   rst   in  synchronous reset, active-high, loads RST_VALUE
//   load  in  capture d on the next edge
//   d     in  DATA_WIDTH payload to capture
//   q     out DATA_WIDTH registered payload
module pipe_data_reg #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RST_VALUE  = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] q
);

   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] data_d;

   // Hold unless loading.
   always_comb begin
      data_d = data_q;
      if (load) begin
         data_d = d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= RST_VALUE;
      end else begin
         data_q <= data_d;
      end
   end

   assign q = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Purpose: two-entry pipeline stage (main + skid) with valid/ready handshake and flush.
//   in_ready depends only on the state flop, so no combinational path from out_ready.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   flush               kill stage contents (any same-cycle acceptance is discarded)
//   in_valid/in_ready   upstream handshake, in_data payload
//   out_valid/out_ready downstream handshake, out_data is always the main register
//   count               entries held: 0, 1 or 2
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RST_VALUE  = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [COUNT_W-1:0]    count
);

   pipe_state_t           state_q;
   pipe_state_t           state_d;
   logic                  acc;
   logic                  pop;
   logic                  main_load;
   logic                  skid_load;
   logic                  main_from_skid;
   logic [DATA_WIDTH-1:0] main_d;
   logic [DATA_WIDTH-1:0] skid_q;

   // Handshake outputs decoded from the state flop only.
   assign out_valid = (state_q != PS_EMPTY);
   assign in_ready  = (state_q != PS_FULL);
   assign acc       = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Next state and data-register load controls.
   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      skid_load      = 1'b0;
      main_from_skid = 1'b0;
      if (flush) begin
         // Data registers hold; only occupancy is cleared.
         state_d = PS_EMPTY;
      end else begin
         unique case (state_q)
            PS_EMPTY: begin
               if (acc) begin
                  main_load = 1'b1;
                  state_d   = PS_BUSY;
               end
            end
            PS_BUSY: begin
               if (acc && pop) begin
                  main_load = 1'b1;
               end else if (acc) begin
                  skid_load = 1'b1;
                  state_d   = PS_FULL;
               end else if (pop) begin
                  state_d = PS_EMPTY;
               end
            end
            PS_FULL: begin
               // in_ready is low here, so only a pop can happen.
               if (pop) begin
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
                  state_d        = PS_BUSY;
               end
            end
            default: state_d = PS_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PS_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Main register refills from skid when draining a full stage.
   assign main_d = main_from_skid ? skid_q : in_data;

   // Occupancy count decode.
   always_comb begin
      count = COUNT_W'(0);
      unique case (state_q)
         PS_BUSY: count = COUNT_W'(1);
         PS_FULL: count = COUNT_W'(2);
         default: count = COUNT_W'(0);
      endcase
   end

   pipe_data_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .RST_VALUE  (RST_VALUE)
   ) u_main_reg (
      .clk  (clk),
      .rst  (rst),
      .load (main_load),
      .d    (main_d),
      .q    (out_data)
   );

   pipe_data_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .RST_VALUE  (RST_VALUE)
   ) u_skid_reg (
      .clk  (clk),
      .rst  (rst),
      .load (skid_load),
      .d    (in_data),
      .q    (skid_q)
   );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Purpose: self-checking bench for pipe_skid_reg; directed scenarios plus random
//   valid/ready/flush traffic compared against a queue-based occupancy model.
module tb_pipe_skid_reg;
   import pipe_pkg::*;

   localparam int unsigned DW = 32;

   logic               clk = 1'b0;
   logic               rst;
   logic               flush;
   logic               in_valid;
   logic               in_ready;
   logic [DW-1:0]      in_data;
   logic               out_valid;
   logic               out_ready;
   logic [DW-1:0]      out_data;
   logic [COUNT_W-1:0] count;

   int checks = 0;
   int errors = 0;

   // Model: queue of held payloads (head = what sits downstream) and the
   // value the main register is expected to show, which persists after drain/flush.
   logic [DW-1:0] mq[$];
   logic [DW-1:0] main_exp;

   always #5 clk = ~clk;

   pipe_skid_reg #(
      .DATA_WIDTH (DW),
      .RST_VALUE  ('0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic compare_model();
      check("out_valid", DW'(out_valid), DW'(mq.size() > 0));
      check("in_ready", DW'(in_ready), DW'(mq.size() < 2));
      check("count", DW'(count), DW'(mq.size()));
      check("out_data", out_data, main_exp);
      check("count_max", DW'(count <= 2'd2), DW'(1));
   endtask

   // One clock: drive inputs, advance model at the edge, sample #1 after.
   task automatic step(input logic r, input logic f, input logic iv,
                       input logic [DW-1:0] d, input logic ordy);
      bit            acc;
      bit            pop;
      bit            stall;
      logic [DW-1:0] prev;
      rst       = r;
      flush     = f;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      acc   = iv && (mq.size() < 2);
      pop   = (mq.size() > 0) && ordy;
      stall = (mq.size() > 0) && !ordy && !r && !f;
      prev  = main_exp;
      @(posedge clk);
      if (r) begin
         mq.delete();
         main_exp = '0;
      end else if (f) begin
         mq.delete();
      end else begin
         if (pop) void'(mq.pop_front());
         if (acc) mq.push_back(d);
      end
      if (mq.size() > 0) main_exp = mq[0];
      #1;
      compare_model();
      if (stall) check("stall_hold", out_data, prev);
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      main_exp  = '0;

      // Reset.
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      check("rst_out_valid", DW'(out_valid), DW'(0));
      check("rst_in_ready", DW'(in_ready), DW'(1));
      check("rst_count", DW'(count), DW'(0));
      check("rst_out_data", out_data, DW'(0));

      // Streaming: one cycle latency, count stays at 1.
      for (int i = 1; i <= 8; i++) begin
         step(1'b0, 1'b0, 1'b1, DW'(i), 1'b1);
         check("stream_data", out_data, DW'(i));
         check("stream_count", DW'(count), DW'(1));
         check("stream_in_ready", DW'(in_ready), DW'(1));
      end
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
      check("stream_drain", DW'(count), DW'(0));

      // Back-pressure fills skid, then drains in order.
      step(1'b0, 1'b0, 1'b1, DW'(32'hA), 1'b0);
      step(1'b0, 1'b0, 1'b1, DW'(32'hB), 1'b0);
      check("bp_count", DW'(count), DW'(2));
      check("bp_in_ready", DW'(in_ready), DW'(0));
      check("bp_data", out_data, DW'(32'hA));
      step(1'b0, 1'b0, 1'b1, DW'(32'hC), 1'b0);
      check("bp_hold", out_data, DW'(32'hA));
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
      check("bp_pop1_data", out_data, DW'(32'hB));
      check("bp_pop1_count", DW'(count), DW'(1));
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
      check("bp_pop2_count", DW'(count), DW'(0));

      // Flush while full, same cycle as a pop attempt.
      step(1'b0, 1'b0, 1'b1, DW'(32'hA), 1'b0);
      step(1'b0, 1'b0, 1'b1, DW'(32'hB), 1'b0);
      step(1'b0, 1'b1, 1'b0, '0, 1'b1);
      check("flush_count", DW'(count), DW'(0));
      check("flush_out_valid", DW'(out_valid), DW'(0));
      check("flush_in_ready", DW'(in_ready), DW'(1));
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
      check("flush_no_b", DW'(out_valid), DW'(0));

      // Flush discards a same-cycle acceptance while empty.
      step(1'b0, 1'b1, 1'b1, DW'(32'h55), 1'b1);
      check("flush_acc_valid", DW'(out_valid), DW'(0));
      step(1'b0, 1'b0, 1'b0, '0, 1'b1);
      check("flush_acc_after", DW'(out_valid), DW'(0));

      // Random traffic with occasional flush and rare reset.
      for (int n = 0; n < 10000; n++) begin
         step(1'b0 | ($urandom_range(0, 999) == 0),
              1'b0 | ($urandom_range(0, 63) == 0),
              1'b0 | ($urandom_range(0, 3) != 0),
              DW'($urandom),
              1'b0 | ($urandom_range(0, 3) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
